// File: rtl/resolver_channel_router_if.sv
// Tagged sample stream bundle: LANES parallel data/dest/user/valid lanes with per-lane ready.
interface resolver_channel_router_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEST_W = 8,
    parameter int unsigned USER_W = 8,
    parameter int unsigned LANES  = 1
);
    logic [LANES*DATA_W-1:0] data;
    logic [LANES*DEST_W-1:0] dest;
    logic [LANES*USER_W-1:0] user;
    logic [LANES-1:0]        valid;
    logic [LANES-1:0]        ready;

    modport master (output data, dest, user, valid, input ready);
    modport slave  (input data, dest, user, valid, output ready);
endinterface

// File: rtl/resolver_channel_router.sv
// Routes tagged resolver samples to per-channel output registers with decimation,
// sticky fault capture and overflow counting. Define RESOLVER_ROUNDING_EN for round-half-up conversion.
module resolver_channel_router #(
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned N_CHANNELS = 2,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned DEST_BASE  = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    resolver_channel_router_if.slave   in_bus,
    resolver_channel_router_if.master  out_bus,
    input  logic [N_CHANNELS*8-1:0]    cfg_decimation,
    input  logic                       fault_clear,
    output logic [USER_WIDTH-1:0]      fault_status,
    output logic [15:0]                overflow_count
);
    localparam int unsigned SHIFT = IN_WIDTH - OUT_WIDTH;
    localparam int unsigned CNT_W = 8;

    logic [IN_WIDTH-1:0]              in_data_c;
    logic [OUT_WIDTH-1:0]             conv_c;
    logic                             in_ready_q;
    logic [N_CHANNELS*OUT_WIDTH-1:0]  out_data_q;
    logic [N_CHANNELS*USER_WIDTH-1:0] out_user_q;
    logic [N_CHANNELS-1:0]            out_valid_q;
    logic [CNT_W-1:0]                 cnt_q [N_CHANNELS];
    logic [USER_WIDTH-1:0]            fault_q;
    logic [15:0]                      overflow_q;

    logic [N_CHANNELS-1:0] hit_c, fwd_c, hs_c, load_c, drop_c;
    logic                  bad_dest_c;

    assign in_data_c = in_bus.data;

`ifdef RESOLVER_ROUNDING_EN
    // Round half up in two's complement; positive overflow clamps to the max code.
    if (SHIFT == 0) begin : g_no_round
        assign conv_c = OUT_WIDTH'(in_data_c);
    end else begin : g_round
        localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1) << (SHIFT - 1);
        logic [IN_WIDTH:0] sum_c;
        assign sum_c  = {in_data_c[IN_WIDTH-1], in_data_c} + HALF;
        assign conv_c = (sum_c[IN_WIDTH] != sum_c[IN_WIDTH-1])
                      ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                      : OUT_WIDTH'(sum_c[IN_WIDTH-1:0] >> SHIFT);
    end
`else
    assign conv_c = OUT_WIDTH'(in_data_c >> SHIFT);
`endif

    // Per-channel routing, decimation gate and register availability.
    always_comb begin
        hit_c  = '0;
        fwd_c  = '0;
        hs_c   = '0;
        load_c = '0;
        drop_c = '0;
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            hit_c[i]  = in_bus.valid[0] && (in_bus.dest == DEST_WIDTH'(i));
            fwd_c[i]  = hit_c[i] && (cnt_q[i] == '0);
            hs_c[i]   = out_valid_q[i] && out_bus.ready[i];
            load_c[i] = fwd_c[i] && (!out_valid_q[i] || hs_c[i]);
            drop_c[i] = fwd_c[i] && out_valid_q[i] && !out_bus.ready[i];
        end
        bad_dest_c = in_bus.valid[0] && (in_bus.dest >= DEST_WIDTH'(N_CHANNELS));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= '0;
            out_valid_q <= '0;
            fault_q     <= '0;
            overflow_q  <= '0;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            in_ready_q <= 1'b1;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                if (hit_c[i]) begin
                    cnt_q[i] <= (cnt_q[i] >= cfg_decimation[i*CNT_W +: CNT_W])
                              ? '0 : cnt_q[i] + CNT_W'(1);
                end
                if (load_c[i]) begin
                    out_data_q[i*OUT_WIDTH +: OUT_WIDTH]   <= conv_c;
                    out_user_q[i*USER_WIDTH +: USER_WIDTH] <= in_bus.user;
                    out_valid_q[i]                         <= 1'b1;
                end else if (hs_c[i]) begin
                    out_valid_q[i] <= 1'b0;
                end
            end
            if ((bad_dest_c || (|drop_c)) && (overflow_q != 16'hFFFF)) begin
                overflow_q <= overflow_q + 16'd1;
            end
            // A beat arriving with fault_clear replaces the status with its own fault.
            if (in_bus.valid[0]) begin
                fault_q <= fault_clear ? in_bus.user : (fault_q | in_bus.user);
            end else if (fault_clear) begin
                fault_q <= '0;
            end
        end
    end

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_dest
        assign out_bus.dest[g*DEST_WIDTH +: DEST_WIDTH] = DEST_WIDTH'(DEST_BASE + g);
    end

    assign in_bus.ready    = in_ready_q;
    assign out_bus.data    = out_data_q;
    assign out_bus.user    = out_user_q;
    assign out_bus.valid   = out_valid_q;
    assign fault_status    = fault_q;
    assign overflow_count  = overflow_q;

endmodule
